pwm_brightness_sequencer: RTL and testbench
===========================================

// Module: pwm_brightness_sequencer
// PURPOSE
//   Upstream stage of the PWM LED dimmer: generates its W-bit duty word w.
//   Three modes:
//   - static: w follows a level input.
//   - manual: single-cycle up/down pulses step w, saturating at the limits.
//   - breathe: w ramps 0 -> max -> 0 continuously, dwelling at each extreme.
//   All updates are paced by an internal step-tick divider.
// PARAMETERS
//   W          4        width of duty word w
//   TICK_DIV   500000   clk cycles per step tick (>=2)
//   HOLD_STEPS 8        step ticks dwelt at top/bottom in breathe mode (>=1)
// PORTS
//   clk        in   1   system clock, all logic on rising edge
//   rst_n      in   1   asynchronous reset, active-low
//   en         in   1   1 = sequencer runs; 0 = freeze w, clear divider
//   mode       in   2   00 static, 01 breathe, 10 manual, 11 = treated as static
//   level_in   in   W   target duty word in static mode
//   up_pulse   in   1   manual increment request (1-cycle pulse)
//   dn_pulse   in   1   manual decrement request (1-cycle pulse)
//   w          out  W   registered duty word to PWM dimmer
//   step_tick  out  1   registered 1-cycle strobe each TICK_DIV cycles (when en)
//   phase      out  2   breathe state: 00 RISE, 01 HOLD_HI, 10 FALL, 11 HOLD_LO
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - w=0, step_tick=0, phase=RISE, tick_cnt=0, hold_cnt=0, pending up/dn flags=0.
//   Divider:
//   - With en=1, tick_cnt counts 0..TICK_DIV-1 and wraps.
//   - step_tick=1 in the cycle after tick_cnt==TICK_DIV-1.
//   - With en=0, tick_cnt=0, step_tick=0, w/phase/hold_cnt held.
//   Static mode:
//   - w <= level_in on every step_tick, so latency is <= TICK_DIV+1 cycles.
//   Manual mode:
//   - up/dn pulses are latched into pending flags at any cycle.
//   - On step_tick: up-only -> w+1, saturating at 2^W-1; dn-only -> w-1, saturating at 0.
//   - Both pending -> no change. Flags clear on that step_tick.
//   - Flags also clear on leaving manual mode.
//   - Pulses arriving while en=0 are ignored.
//   Breathe mode (state advances only on step_tick):
//   - RISE: w+1; on the tick where w becomes max -> HOLD_HI, hold_cnt=0.
//   - HOLD_HI: hold_cnt+1; at hold_cnt==HOLD_STEPS-1 -> FALL.
//   - FALL: w-1; on the tick where w becomes 0 -> HOLD_LO, hold_cnt=0.
//   - HOLD_LO: hold_cnt+1; at hold_cnt==HOLD_STEPS-1 -> RISE.
//   - Full period = 2*(2^W-1 + HOLD_STEPS) step ticks.
//   Mode changes:
//   - Entering breathe: ramp continues from the current w.
//   - The phase is set on the entry cycle: RISE if w<max, else HOLD_HI, with hold_cnt=0.
//   - Leaving breathe: phase is held; w is then owned by the new mode.
//   Arithmetic:
//   - Never wraps: max+1 stays max, 0-1 stays 0 (in all modes).
//   Reset mid-operation:
//   - Immediate return to reset values, including during a HOLD or with pending flags.
// TESTING (sim with TICK_DIV=4, HOLD_STEPS=2, W=4)
//   - Reset: rst_n low mid-ramp at w=7 -> w=0, phase=RISE and step_tick=0 within
//     the same cycle, no clk edge needed.
//   - Static: mode=00, level_in=4'b0010 -> w=2 after first step_tick; step_tick
//     period is exactly 4 clks.
//   - Manual: 3 up_pulses spaced >4 clks -> w=3. 20 up_pulses -> w saturates at 15.
//     up and dn in the same tick window -> w unchanged.
//   - Breathe: from reset, w steps 0..15, holds 2 ticks, falls 15..0, holds 2 ticks.
//     The sequence repeats every 34 ticks (136 clks); phase codes follow RISE/HOLD_HI/FALL/HOLD_LO.
//   - Enable gating: en=0 at w=9 for 50 clks -> w stays 9, no step_tick.
//     After en=1, the first step_tick is 4 clks later.
//   - Mode switch: breathe at w=15 in HOLD_HI -> manual, dn_pulse -> w=14.
//     Back to breathe -> phase=RISE, ramp resumes from 14.

Source files
------------

// File: rtl/pwm_brightness_sequencer.sv
// Duty-word sequencer for the PWM dimmer: static level, manual up/down, or breathe ramp, paced by a step-tick divider.
// Latency: w changes on the clock edge that ends a step_tick cycle; no backpressure (en=0 freezes w and clears the divider).
module pwm_brightness_sequencer #(
    parameter int W          = 4,
    parameter int TICK_DIV   = 500000,
    parameter int HOLD_STEPS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [1:0]   mode,
    input  logic [W-1:0] level_in,
    input  logic         up_pulse,
    input  logic         dn_pulse,
    output logic [W-1:0] w,
    output logic         step_tick,
    output logic [1:0]   phase
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [W-1:0] WMAX = '1;

    typedef enum logic [1:0] {
        RISE    = 2'b00,
        HOLD_HI = 2'b01,
        FALL    = 2'b10,
        HOLD_LO = 2'b11
    } phase_t;

    phase_t          state, state_nxt;
    logic [TW-1:0]   tick_cnt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [W-1:0]    w_nxt, w_inc, w_dec;
    logic            up_pend, up_nxt, dn_pend, dn_nxt;
    logic            in_brth, in_brth_nxt;
    logic            is_man, is_brth;

    assign is_man  = (mode == 2'b10);
    assign is_brth = (mode == 2'b01);
    assign w_inc   = (w == WMAX) ? w : w + 1'b1;
    assign w_dec   = (w == '0)   ? w : w - 1'b1;
    assign phase   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (!en) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= (tick_cnt == TW'(TICK_DIV - 1));
            tick_cnt  <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        w_nxt       = w;
        up_nxt      = up_pend;
        dn_nxt      = dn_pend;
        in_brth_nxt = in_brth;
        if (en) begin
            in_brth_nxt = is_brth;
            if (!is_man) begin
                up_nxt = 1'b0;
                dn_nxt = 1'b0;
            end else begin
                // A pulse landing in the tick cycle itself is consumed by that tick.
                up_nxt = up_pend | up_pulse;
                dn_nxt = dn_pend | dn_pulse;
                if (step_tick) begin
                    if (up_nxt && !dn_nxt)
                        w_nxt = w_inc;
                    else if (dn_nxt && !up_nxt)
                        w_nxt = w_dec;
                    up_nxt = 1'b0;
                    dn_nxt = 1'b0;
                end
            end

            if (is_brth && !in_brth) begin
                state_nxt = (w == WMAX) ? HOLD_HI : RISE;
                hold_nxt  = '0;
            end else if (is_brth && step_tick) begin
                case (state)
                    RISE: begin
                        w_nxt = w_inc;
                        if (w_inc == WMAX) begin
                            state_nxt = HOLD_HI;
                            hold_nxt  = '0;
                        end
                    end
                    HOLD_HI: begin
                        if (hold_cnt == HW'(HOLD_STEPS - 1))
                            state_nxt = FALL;
                        else
                            hold_nxt = hold_cnt + 1'b1;
                    end
                    FALL: begin
                        w_nxt = w_dec;
                        if (w_dec == '0) begin
                            state_nxt = HOLD_LO;
                            hold_nxt  = '0;
                        end
                    end
                    default: begin
                        if (hold_cnt == HW'(HOLD_STEPS - 1))
                            state_nxt = RISE;
                        else
                            hold_nxt = hold_cnt + 1'b1;
                    end
                endcase
            end else if (!is_brth && !is_man && step_tick) begin
                w_nxt = level_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RISE;
            hold_cnt <= '0;
            w        <= '0;
            up_pend  <= 1'b0;
            dn_pend  <= 1'b0;
            in_brth  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            w        <= w_nxt;
            up_pend  <= up_nxt;
            dn_pend  <= dn_nxt;
            in_brth  <= in_brth_nxt;
        end
    end
endmodule

// File: tb/tb_pwm_brightness_sequencer.sv
// Bench for pwm_brightness_sequencer: directed scenarios then random traffic against a period-position reference model.
module tb_pwm_brightness_sequencer;
    localparam int W    = 4;
    localparam int TD   = 4;
    localparam int HS   = 2;
    localparam int MAXW = 15;
    localparam int PER  = 2 * (MAXW + HS);

    logic       clk = 1'b0;
    logic       rst_n, en, up_pulse, dn_pulse, step_tick;
    logic [1:0] mode, phase;
    logic [3:0] level_in, w;

    int vectors = 0;
    int errs    = 0;

    // Reference model state
    int         m_w, m_pos, m_cnt;
    bit         m_tick, m_pu, m_pd, m_inb;
    logic [1:0] m_ph;
    logic [3:0] exp_w;
    bit         found;

    always #5 clk = ~clk;

    pwm_brightness_sequencer #(.W(W), .TICK_DIV(TD), .HOLD_STEPS(HS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .level_in(level_in),
        .up_pulse(up_pulse), .dn_pulse(dn_pulse), .w(w), .step_tick(step_tick), .phase(phase)
    );

    // Position within one breathe period, 0 = rising from w=0.
    function automatic int w_of(int p);
        if (p < MAXW) return p;
        if (p < MAXW + HS) return MAXW;
        if (p < 2 * MAXW + HS) return 2 * MAXW + HS - p;
        return 0;
    endfunction

    function automatic logic [1:0] ph_of(int p);
        if (p < MAXW) return 2'b00;
        if (p < MAXW + HS) return 2'b01;
        if (p < 2 * MAXW + HS) return 2'b10;
        return 2'b11;
    endfunction

    task automatic model_reset();
        m_w = 0; m_pos = 0; m_cnt = 0; m_tick = 0;
        m_pu = 0; m_pd = 0; m_inb = 0; m_ph = 2'b00;
    endtask

    task automatic model_edge();
        bit old_tick;
        old_tick = m_tick;
        if (en) begin
            if (mode == 2'b10) begin
                m_pu = m_pu | up_pulse;
                m_pd = m_pd | dn_pulse;
                if (old_tick) begin
                    if (m_pu && !m_pd && m_w < MAXW) m_w = m_w + 1;
                    if (m_pd && !m_pu && m_w > 0) m_w = m_w - 1;
                    m_pu = 0; m_pd = 0;
                end
            end else begin
                m_pu = 0; m_pd = 0;
            end
            if (mode == 2'b01) begin
                if (!m_inb) begin
                    m_pos = (m_w >= MAXW) ? MAXW : m_w;
                    m_ph  = ph_of(m_pos);
                end else if (old_tick) begin
                    m_pos = (m_pos + 1) % PER;
                    m_w   = w_of(m_pos);
                    m_ph  = ph_of(m_pos);
                end
            end else if (mode != 2'b10 && old_tick) begin
                m_w = int'(level_in);
            end
            m_inb  = (mode == 2'b01);
            m_cnt  = m_cnt + 1;
            m_tick = (m_cnt % TD) == 0;
        end else begin
            m_cnt  = 0;
            m_tick = 0;
        end
    endtask

    task automatic check(string tag);
        exp_w = 4'(m_w);
        vectors += 3;
        assert (w === exp_w) else begin
            errs++; $error("FAIL %s w: got %0d expected %0d", tag, w, exp_w);
        end
        assert (step_tick === m_tick) else begin
            errs++; $error("FAIL %s step_tick: got %0b expected %0b", tag, step_tick, m_tick);
        end
        assert (phase === m_ph) else begin
            errs++; $error("FAIL %s phase: got %0d expected %0d", tag, phase, m_ph);
        end
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic do_reset(string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check(tag);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_up(int gap);
        up_pulse = 1'b1; cyc("manual_up");
        up_pulse = 1'b0;
        repeat (gap) cyc("manual_up");
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; level_in = 4'd0;
        up_pulse = 1'b0; dn_pulse = 1'b0;
        model_reset();
        #3;
        check("reset");
        #5;
        rst_n = 1'b1;

        // Static mode: w picks up level_in on the first tick, tick period 4
        en = 1'b1; mode = 2'b00; level_in = 4'b0010;
        repeat (5) cyc("static");
        vectors++;
        assert (w === 4'd2) else begin errs++; $error("FAIL static_level w: got %0d expected 2", w); end
        repeat (12) cyc("static_period");
        mode = 2'b11; level_in = 4'd11;
        repeat (9) cyc("mode11");

        // Manual stepping and saturation
        do_reset("reset_manual");
        mode = 2'b10;
        repeat (3) pulse_up(5);
        repeat (4) cyc("manual_up");
        vectors++;
        assert (w === 4'd3) else begin errs++; $error("FAIL manual_3up w: got %0d expected 3", w); end
        repeat (20) pulse_up(4);
        repeat (5) cyc("manual_sat");
        vectors++;
        assert (w === 4'd15) else begin errs++; $error("FAIL manual_sat w: got %0d expected 15", w); end
        dn_pulse = 1'b1; cyc("manual_dn"); dn_pulse = 1'b0;
        repeat (5) cyc("manual_dn");
        up_pulse = 1'b1; cyc("manual_both"); up_pulse = 1'b0;
        dn_pulse = 1'b1; cyc("manual_both"); dn_pulse = 1'b0;
        repeat (6) cyc("manual_both");
        vectors++;
        assert (w === 4'd14) else begin errs++; $error("FAIL manual_both w: got %0d expected 14", w); end

        // Breathe from reset over two full periods
        do_reset("reset_breathe");
        mode = 2'b01;
        repeat (2 * PER * TD + 8) cyc("breathe");

        // Asynchronous reset mid-ramp at w=7
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            cyc("breathe_to7");
            found = (m_w == 7 && m_ph == 2'b00);
        end
        vectors++;
        assert (found) else begin errs++; $error("FAIL wait_w7: got timeout expected w=7"); end
        do_reset("async_reset");
        repeat (10) cyc("after_reset");

        // Enable gating at w=9
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            cyc("breathe_to9");
            found = (m_w == 9);
        end
        vectors++;
        assert (found) else begin errs++; $error("FAIL wait_w9: got timeout expected w=9"); end
        en = 1'b0;
        repeat (50) cyc("en_off");
        vectors++;
        assert (w === 4'd9) else begin errs++; $error("FAIL en_hold w: got %0d expected 9", w); end
        en = 1'b1;
        repeat (12) cyc("en_on");

        // Mode switch from HOLD_HI to manual and back
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            cyc("breathe_to_hold");
            found = (m_ph == 2'b01);
        end
        vectors++;
        assert (found) else begin errs++; $error("FAIL wait_hold_hi: got timeout expected HOLD_HI"); end
        mode = 2'b10; dn_pulse = 1'b1; cyc("switch_manual"); dn_pulse = 1'b0;
        repeat (6) cyc("switch_manual");
        vectors++;
        assert (w === 4'd14) else begin errs++; $error("FAIL switch_dn w: got %0d expected 14", w); end
        mode = 2'b01;
        cyc("switch_breathe");
        vectors++;
        assert (phase === 2'b00) else begin errs++; $error("FAIL switch_rise phase: got %0d expected 0", phase); end
        repeat (24) cyc("switch_breathe");

        // Random traffic
        do_reset("reset_random");
        for (int i = 0; i < 800; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            level_in = 4'($urandom_range(0, 15));
            up_pulse = ($urandom_range(0, 5) == 0);
            dn_pulse = ($urandom_range(0, 6) == 0);
            if ($urandom_range(0, 199) == 0) do_reset("random_reset");
            else cyc("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
